// File: rtl/da_lut_loader.sv
// da_lut_loader: writer side of the FIR distributed-arithmetic lookup table.
// Loads TAPS signed coefficients over a valid/ready stream, then emits all
// 2^TAPS addresses in order. Each entry's data is the sum of the coefficients
// whose address bit is set.
module da_lut_loader #(
   parameter int TAPS   = 8,
   parameter int COEF_W = 8,
   parameter int SUM_W  = COEF_W + $clog2(TAPS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     coef_valid,
   input  logic signed [COEF_W-1:0] coef_data,
   output logic                     coef_ready,
   output logic                     wr_valid,
   input  logic                     wr_ready,
   output logic [TAPS-1:0]          wr_addr,
   output logic signed [SUM_W-1:0]  wr_data,
   output logic                     busy,
   output logic                     done
);

   localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_WRITE,
      S_DONE
   } state_t;

   state_t                    state_q, state_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [TAPS-1:0]           addr_q, addr_d;
   logic signed [COEF_W-1:0]  coef_q [TAPS];
   logic signed [COEF_W-1:0]  coef_d [TAPS];
   logic                      coef_ready_q, coef_ready_d;
   logic                      wr_valid_q, wr_valid_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic [SUM_W-1:0]          wr_data_q, wr_data_d;
   logic [SUM_W-1:0]          psum;

   // Next-state, next-output and next-entry computation.
   // wr_data is precomputed from the next addr/coef values and registered,
   // so the write port is driven purely from flops and holds during stalls.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      addr_d       = addr_q;
      coef_d       = coef_q;
      coef_ready_d = coef_ready_q;
      wr_valid_d   = wr_valid_q;
      done_d       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d      = S_LOAD;
               idx_d        = '0;
               addr_d       = '0;
               coef_ready_d = 1'b1;
            end
         end
         S_LOAD: begin
            if (coef_valid && coef_ready_q) begin
               coef_d[idx_q] = coef_data;
               if (idx_q == IDX_W'(TAPS - 1)) begin
                  state_d      = S_WRITE;
                  idx_d        = '0;
                  addr_d       = '0;
                  coef_ready_d = 1'b0;
                  wr_valid_d   = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         S_WRITE: begin
            if (wr_valid_q && wr_ready) begin
               if (addr_q == '1) begin
                  state_d    = S_DONE;
                  wr_valid_d = 1'b0;
                  done_d     = 1'b1;
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d      = S_IDLE;
            coef_ready_d = 1'b0;
            wr_valid_d   = 1'b0;
         end
      endcase

      busy_d = (state_d == S_LOAD) || (state_d == S_WRITE);

      psum = '0;
      for (int unsigned i = 0; i < TAPS; i++) begin
         if (addr_d[i]) begin
            psum = psum + {{(SUM_W - COEF_W){coef_d[i][COEF_W-1]}}, coef_d[i]};
         end
      end
      wr_data_d = psum;
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         addr_q       <= '0;
         coef_ready_q <= 1'b0;
         wr_valid_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         wr_data_q    <= '0;
         for (int unsigned i = 0; i < TAPS; i++) begin
            coef_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         addr_q       <= addr_d;
         coef_ready_q <= coef_ready_d;
         wr_valid_q   <= wr_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         wr_data_q    <= wr_data_d;
         coef_q       <= coef_d;
      end
   end

   assign coef_ready = coef_ready_q;
   assign wr_valid   = wr_valid_q;
   assign wr_addr    = addr_q;
   assign wr_data    = wr_data_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule
